traffic_lamp_monitor: RTL

//  Consumer of the 2-bit light codes driven by the intersection controller (LA/LB).

---
 rtl/traffic_lamp_monitor.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor between the intersection controller and the lamp drivers.
// Decodes LA/LB into lamp drives, checks each transition, and flashes red on any fault.
module traffic_lamp_monitor #(
  parameter int unsigned MIN_YELLOW = 5,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] LA,
  input  logic [1:0] LB,
  input  logic       clr_fault,
  output logic       ga,
  output logic       ya,
  output logic       ra,
  output logic       gb,
  output logic       yb,
  output logic       rb,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [1:0] C_G = 2'b00;
  localparam logic [1:0] C_Y = 2'b01;
  localparam logic [1:0] C_R = 2'b10;
  localparam logic [1:0] C_X = 2'b11;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_ILL   = 3'd1;
  localparam logic [2:0] F_CONF  = 3'd2;
  localparam logic [2:0] F_SEQ   = 3'd3;
  localparam logic [2:0] F_SHORT = 3'd4;

  // lamp vector order: {ga, ya, ra, gb, yb, rb}
  localparam logic [5:0] LAMPS_RED = 6'b001_001;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FAULT  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      la_q, la_d;
  logic [1:0]      lb_q, lb_d;
  logic [YW-1:0]   ycnt_a_q, ycnt_a_d;
  logic [YW-1:0]   ycnt_b_q, ycnt_b_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic            phase_q, phase_d;
  logic [5:0]      lamp_q, lamp_d;
  logic            fault_q, fault_d;
  logic [2:0]      code_q, code_d;
  logic [2:0]      viol_c;

  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      C_G:     ok = (cur == C_G) || (cur == C_Y);
      C_Y:     ok = (cur == C_Y) || (cur == C_R);
      C_R:     ok = (cur == C_R) || (cur == C_G);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [YW-1:0] ycnt_next(input logic [1:0] cur, input logic [YW-1:0] cnt);
    logic [YW-1:0] n;
    n = '0;
    if (cur == C_Y) begin
      n = (cnt == YW'(MIN_YELLOW)) ? cnt : cnt + YW'(1);
    end
    return n;
  endfunction

  function automatic logic [2:0] decode(input logic [1:0] c);
    return {c == C_G, c == C_Y, c == C_R};
  endfunction

  // Lowest-numbered violation wins when several hit in the same sample.
  always_comb begin
    viol_c = F_NONE;
    if ((LA == C_X) || (LB == C_X)) begin
      viol_c = F_ILL;
    end else if ((LA != C_R) && (LB != C_R)) begin
      viol_c = F_CONF;
    end else if (!legal_step(la_q, LA) || !legal_step(lb_q, LB)) begin
      viol_c = F_SEQ;
    end else if (((la_q == C_Y) && (LA == C_R) && (ycnt_a_q < YW'(MIN_YELLOW))) ||
                 ((lb_q == C_Y) && (LB == C_R) && (ycnt_b_q < YW'(MIN_YELLOW)))) begin
      viol_c = F_SHORT;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    la_d     = la_q;
    lb_d     = lb_q;
    ycnt_a_d = ycnt_a_q;
    ycnt_b_d = ycnt_b_q;
    flash_d  = flash_q;
    phase_d  = phase_q;
    lamp_d   = lamp_q;
    fault_d  = fault_q;
    code_d   = code_q;

    case (state_q)
      S_NORMAL: begin
        if (viol_c != F_NONE) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = viol_c;
          lamp_d  = LAMPS_RED;
          flash_d = '0;
          phase_d = 1'b1;
        end else begin
          lamp_d   = {decode(LA), decode(LB)};
          la_d     = LA;
          lb_d     = LB;
          ycnt_a_d = ycnt_next(LA, ycnt_a_q);
          ycnt_b_d = ycnt_next(LB, ycnt_b_q);
        end
      end
      S_FAULT: begin
        if (clr_fault && (LA == C_R) && (LB == C_R)) begin
          state_d  = S_NORMAL;
          fault_d  = 1'b0;
          code_d   = F_NONE;
          la_d     = C_R;
          lb_d     = C_R;
          ycnt_a_d = '0;
          ycnt_b_d = '0;
          flash_d  = '0;
          phase_d  = 1'b1;
          lamp_d   = LAMPS_RED;
        end else begin
          if (flash_q == FW'(FLASH_HALF - 1)) begin
            flash_d = '0;
            phase_d = ~phase_q;
          end else begin
            flash_d = flash_q + FW'(1);
          end
          lamp_d = {2'b00, phase_d, 2'b00, phase_d};
        end
      end
      default: begin
        state_d = S_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_NORMAL;
      la_q     <= C_R;
      lb_q     <= C_R;
      ycnt_a_q <= '0;
      ycnt_b_q <= '0;
      flash_q  <= '0;
      phase_q  <= 1'b1;
      lamp_q   <= LAMPS_RED;
      fault_q  <= 1'b0;
      code_q   <= F_NONE;
    end else begin
      state_q  <= state_d;
      la_q     <= la_d;
      lb_q     <= lb_d;
      ycnt_a_q <= ycnt_a_d;
      ycnt_b_q <= ycnt_b_d;
      flash_q  <= flash_d;
      phase_q  <= phase_d;
      lamp_q   <= lamp_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  assign ga         = lamp_q[5];
  assign ya         = lamp_q[4];
  assign ra         = lamp_q[3];
  assign gb         = lamp_q[2];
  assign yb         = lamp_q[1];
  assign rb         = lamp_q[0];
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule
